panda_risc_v_div_scheduler: RTL and testbench

//  Dispatch/completion controller in front of the multi-cycle 33-bit divider in the EXU.
//  - Decodes RV32M DIV/DIVU/REM/REMU into signed 33-bit operands plus a rem-select bit.
//  - Issues requests to the divider and caps the number of ops in flight.
//  - Discards results of ops killed by a pipeline flush.
//  - Returns a repeated identical division from a 1-entry result cache without running the divider.

---
 rtl/panda_risc_v_div_scheduler.sv | 142 ++++++++++++++
 tb/tb_panda_risc_v_div_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panda_risc_v_div_scheduler.sv
// Dispatch/completion controller for the 33-bit multi-cycle divider: operand extension,
// in-flight cap, flush kill accounting and a 1-entry result cache for repeated divisions.
module panda_risc_v_div_scheduler #(
  parameter int inst_id_width   = 4,
  parameter int max_outstanding = 3,
  parameter bit en_res_cache    = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,

  input  logic [1:0]               s_req_op,
  input  logic [31:0]              s_req_op_a,
  input  logic [31:0]              s_req_op_b,
  input  logic [4:0]               s_req_rd_id,
  input  logic [inst_id_width-1:0] s_req_inst_id,
  input  logic                     s_req_valid,
  output logic                     s_req_ready,

  output logic [32:0]              m_div_req_op_a,
  output logic [32:0]              m_div_req_op_b,
  output logic                     m_div_req_rem_sel,
  output logic [4:0]               m_div_req_rd_id,
  output logic [inst_id_width-1:0] m_div_req_inst_id,
  output logic                     m_div_req_valid,
  input  logic                     m_div_req_ready,

  input  logic [31:0]              s_div_res_data,
  input  logic [4:0]               s_div_res_rd_id,
  input  logic [inst_id_width-1:0] s_div_res_inst_id,
  input  logic                     s_div_res_valid,
  output logic                     s_div_res_ready,

  output logic [31:0]              m_res_data,
  output logic [4:0]               m_res_rd_id,
  output logic [inst_id_width-1:0] m_res_inst_id,
  output logic                     m_res_valid,
  input  logic                     m_res_ready
);

  localparam int tag_w = 66;

  logic [2:0]       outstanding;
  logic [2:0]       kill_cnt;
  logic [tag_w-1:0] req_tag;
  logic [tag_w-1:0] last_tag;
  logic [tag_w-1:0] cache_tag;
  logic [31:0]      cache_data;
  logic             cache_valid;

  logic hit;
  logic out_free;
  logic below_max;
  logic issue;
  logic hit_acc;
  logic ret;
  logic drop;
  logic deliver;

  assign req_tag = {s_req_op, s_req_op_a, s_req_op_b};

  // op[0] selects unsigned: bit 32 is zero, otherwise a copy of bit 31
  assign m_div_req_op_a    = {~s_req_op[0] & s_req_op_a[31], s_req_op_a};
  assign m_div_req_op_b    = {~s_req_op[0] & s_req_op_b[31], s_req_op_b};
  assign m_div_req_rem_sel = s_req_op[1];
  assign m_div_req_rd_id   = s_req_rd_id;
  assign m_div_req_inst_id = s_req_inst_id;

  // Hits are only allowed while the divider is empty so results stay in issue order
  assign hit = en_res_cache && cache_valid && (outstanding == 3'd0) &&
               (kill_cnt == 3'd0) && (req_tag == cache_tag);

  assign out_free  = !m_res_valid || m_res_ready;
  assign below_max = outstanding < 3'(max_outstanding);

  assign s_req_ready     = !flush && (hit ? out_free : (m_div_req_ready && below_max));
  assign m_div_req_valid = s_req_valid && !flush && !hit && below_max;

  assign issue   = m_div_req_valid && m_div_req_ready;
  assign hit_acc = s_req_valid && s_req_ready && hit;

  // Killed results are always sunk; live ones wait for room in the output register
  assign s_div_res_ready = flush || (kill_cnt != 3'd0) || out_free;
  assign ret             = s_div_res_valid && s_div_res_ready;
  assign drop            = ret && (flush || (kill_cnt != 3'd0));
  assign deliver         = ret && !drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= 3'd0;
      kill_cnt    <= 3'd0;
    end else begin
      outstanding <= outstanding + {2'b00, issue} - {2'b00, ret};
      if (flush)
        kill_cnt <= outstanding - {2'b00, ret};
      else if (drop)
        kill_cnt <= kill_cnt - 3'd1;
    end
  end

  // last_tag follows the youngest issued op; it becomes the cache tag when that op returns
  always_ff @(posedge clk) begin
    if (rst) begin
      last_tag    <= '0;
      cache_tag   <= '0;
      cache_data  <= '0;
      cache_valid <= 1'b0;
    end else begin
      if (issue)
        last_tag <= req_tag;
      if (deliver && (outstanding == 3'd1)) begin
        cache_tag   <= last_tag;
        cache_data  <= s_div_res_data;
        cache_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_res_valid   <= 1'b0;
      m_res_data    <= '0;
      m_res_rd_id   <= '0;
      m_res_inst_id <= '0;
    end else if (flush) begin
      m_res_valid <= 1'b0;
    end else if (hit_acc) begin
      m_res_valid   <= 1'b1;
      m_res_data    <= cache_data;
      m_res_rd_id   <= s_req_rd_id;
      m_res_inst_id <= s_req_inst_id;
    end else if (deliver) begin
      m_res_valid   <= 1'b1;
      m_res_data    <= s_div_res_data;
      m_res_rd_id   <= s_div_res_rd_id;
      m_res_inst_id <= s_div_res_inst_id;
    end else if (m_res_ready) begin
      m_res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_panda_risc_v_div_scheduler.sv
// Directed bench for panda_risc_v_div_scheduler; the bench plays the divider and hands back
// hand-computed quotients/remainders.
module tb_panda_risc_v_div_scheduler;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [1:0]    s_req_op;
  logic [31:0]   s_req_op_a, s_req_op_b;
  logic [4:0]    s_req_rd_id;
  logic [IW-1:0] s_req_inst_id;
  logic          s_req_valid, s_req_ready;
  logic [32:0]   m_div_req_op_a, m_div_req_op_b;
  logic          m_div_req_rem_sel;
  logic [4:0]    m_div_req_rd_id;
  logic [IW-1:0] m_div_req_inst_id;
  logic          m_div_req_valid, m_div_req_ready;
  logic [31:0]   s_div_res_data;
  logic [4:0]    s_div_res_rd_id;
  logic [IW-1:0] s_div_res_inst_id;
  logic          s_div_res_valid, s_div_res_ready;
  logic [31:0]   m_res_data;
  logic [4:0]    m_res_rd_id;
  logic [IW-1:0] m_res_inst_id;
  logic          m_res_valid, m_res_ready;

  panda_risc_v_div_scheduler dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_req_op(s_req_op), .s_req_op_a(s_req_op_a), .s_req_op_b(s_req_op_b),
    .s_req_rd_id(s_req_rd_id), .s_req_inst_id(s_req_inst_id),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .m_div_req_op_a(m_div_req_op_a), .m_div_req_op_b(m_div_req_op_b),
    .m_div_req_rem_sel(m_div_req_rem_sel), .m_div_req_rd_id(m_div_req_rd_id),
    .m_div_req_inst_id(m_div_req_inst_id),
    .m_div_req_valid(m_div_req_valid), .m_div_req_ready(m_div_req_ready),
    .s_div_res_data(s_div_res_data), .s_div_res_rd_id(s_div_res_rd_id),
    .s_div_res_inst_id(s_div_res_inst_id),
    .s_div_res_valid(s_div_res_valid), .s_div_res_ready(s_div_res_ready),
    .m_res_data(m_res_data), .m_res_rd_id(m_res_rd_id), .m_res_inst_id(m_res_inst_id),
    .m_res_valid(m_res_valid), .m_res_ready(m_res_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [IW-1:0] iid);
    s_req_op = op; s_req_op_a = a; s_req_op_b = b;
    s_req_rd_id = rd; s_req_inst_id = iid; s_req_valid = 1'b1;
  endtask

  task automatic div_ret(input logic [31:0] d, input logic [4:0] rd, input logic [IW-1:0] iid);
    s_div_res_data = d; s_div_res_rd_id = rd; s_div_res_inst_id = iid; s_div_res_valid = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] ea;
    logic [32:0] eb;
    logic        hit;
    logic [31:0] res;
  } vec_t;

  vec_t vt[12];

  initial begin
    // op: 00 DIV, 01 DIVU, 10 REM, 11 REMU
    vt[0]  = '{2'b01, 32'd100,        32'd7,          33'h0_0000_0064, 33'h0_0000_0007, 1'b0, 32'd14};
    vt[1]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          33'h1_FFFF_FFF9, 33'h0_0000_0002, 1'b0, 32'hFFFF_FFFD};
    vt[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          33'h1_FFFF_FFF9, 33'h0_0000_0002, 1'b1, 32'hFFFF_FFFD};
    vt[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          33'h1_FFFF_FFF9, 33'h0_0000_0002, 1'b0, 32'hFFFF_FFFF};
    vt[4]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          33'h1_FFFF_FFF9, 33'h0_0000_0002, 1'b1, 32'hFFFF_FFFF};
    vt[5]  = '{2'b00, 32'd100,        32'hFFFF_FFF9,  33'h0_0000_0064, 33'h1_FFFF_FFF9, 1'b0, 32'hFFFF_FFF2};
    vt[6]  = '{2'b01, 32'hFFFF_FFF9,  32'h8000_0000,  33'h0_FFFF_FFF9, 33'h0_8000_0000, 1'b0, 32'd1};
    vt[7]  = '{2'b11, 32'hFFFF_FFF9,  32'h8000_0000,  33'h0_FFFF_FFF9, 33'h0_8000_0000, 1'b0, 32'h7FFF_FFF9};
    vt[8]  = '{2'b01, 32'd5,          32'd0,          33'h0_0000_0005, 33'h0_0000_0000, 1'b0, 32'hFFFF_FFFF};
    vt[9]  = '{2'b01, 32'd5,          32'd0,          33'h0_0000_0005, 33'h0_0000_0000, 1'b1, 32'hFFFF_FFFF};
    vt[10] = '{2'b11, 32'd5,          32'd0,          33'h0_0000_0005, 33'h0_0000_0000, 1'b0, 32'd5};
    vt[11] = '{2'b00, 32'd100,        32'hFFFF_FFF9,  33'h0_0000_0064, 33'h1_FFFF_FFF9, 1'b0, 32'hFFFF_FFF2};

    rst = 1'b1; flush = 1'b0;
    s_req_op = 2'b00; s_req_op_a = '0; s_req_op_b = '0; s_req_rd_id = '0; s_req_inst_id = '0;
    s_req_valid = 1'b0; m_div_req_ready = 1'b1;
    s_div_res_data = '0; s_div_res_rd_id = '0; s_div_res_inst_id = '0; s_div_res_valid = 1'b0;
    m_res_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_m_res_valid", m_res_valid, 0);
    chk("reset_div_res_ready", s_div_res_ready, 1);
    chk("reset_div_req_valid", m_div_req_valid, 0);

    // Table: one op at a time, divider answers one cycle after issue
    for (int i = 0; i < 12; i++) begin
      logic [4:0]    rd;
      logic [IW-1:0] iid;
      rd  = 5'(i);
      iid = IW'(i);
      @(negedge clk);
      drive_req(vt[i].op, vt[i].a, vt[i].b, rd, iid);
      #1;
      chk($sformatf("v%0d_req_ready", i), s_req_ready, 1);
      if (vt[i].hit) begin
        chk($sformatf("v%0d_hit_no_div_req", i), m_div_req_valid, 0);
      end else begin
        chk($sformatf("v%0d_div_req_valid", i), m_div_req_valid, 1);
        chk($sformatf("v%0d_op_a", i), m_div_req_op_a, vt[i].ea);
        chk($sformatf("v%0d_op_b", i), m_div_req_op_b, vt[i].eb);
        chk($sformatf("v%0d_rem_sel", i), m_div_req_rem_sel, vt[i].op[1]);
        chk($sformatf("v%0d_div_rd", i), m_div_req_rd_id, rd);
        chk($sformatf("v%0d_div_iid", i), m_div_req_inst_id, iid);
      end
      @(negedge clk);
      s_req_valid = 1'b0;
      if (!vt[i].hit) begin
        chk($sformatf("v%0d_res_not_early", i), m_res_valid, 0);
        div_ret(vt[i].res, rd, iid);
        #1;
        chk($sformatf("v%0d_div_res_ready", i), s_div_res_ready, 1);
        @(negedge clk);
        s_div_res_valid = 1'b0;
      end
      chk($sformatf("v%0d_res_valid", i), m_res_valid, 1);
      chk($sformatf("v%0d_res_data", i), m_res_data, vt[i].res);
      chk($sformatf("v%0d_res_rd", i), m_res_rd_id, rd);
      chk($sformatf("v%0d_res_iid", i), m_res_inst_id, iid);
      @(negedge clk);
      chk($sformatf("v%0d_res_drop", i), m_res_valid, 0);
    end

    // Outstanding cap: divider stalls after accepting three ops
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_req(2'b01, 32'(10 * (k + 1)), 32'd2, 5'(16 + k), IW'(8 + k));
      #1;
      chk($sformatf("cap_issue%0d", k), s_req_ready, 1);
    end
    @(negedge clk);
    drive_req(2'b01, 32'd40, 32'd2, 5'd19, IW'(11));
    #1;
    chk("cap_4th_blocked", s_req_ready, 0);
    chk("cap_4th_no_div_req", m_div_req_valid, 0);
    @(negedge clk);
    chk("cap_4th_still_blocked", s_req_ready, 0);
    div_ret(32'd5, 5'd16, IW'(8));
    #1;
    chk("cap_ret_same_cycle_blocked", s_req_ready, 0);
    @(negedge clk);
    s_div_res_valid = 1'b0;
    #1;
    chk("cap_4th_released", s_req_ready, 1);
    chk("cap_res0_valid", m_res_valid, 1);
    chk("cap_res0_data", m_res_data, 5);
    @(negedge clk);
    s_req_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      div_ret(32'(5 * (k + 1)), 5'(16 + k), IW'(8 + k));
      @(negedge clk);
      chk($sformatf("cap_res%0d_valid", k), m_res_valid, 1);
      chk($sformatf("cap_res%0d_data", k), m_res_data, 5 * (k + 1));
      chk($sformatf("cap_res%0d_iid", k), m_res_inst_id, 8 + k);
    end
    s_div_res_valid = 1'b0;
    // Youngest op (40/2) returned last, so it is now cached
    drive_req(2'b01, 32'd40, 32'd2, 5'd3, IW'(3));
    #1;
    chk("cap_cache_hit", m_div_req_valid, 0);
    chk("cap_cache_ready", s_req_ready, 1);
    @(negedge clk);
    s_req_valid = 1'b0;
    chk("cap_cache_data", m_res_data, 20);
    chk("cap_cache_rd", m_res_rd_id, 3);

    // Flush with two ops in flight
    drive_req(2'b01, 32'd50, 32'd5, 5'd5, IW'(5));
    @(negedge clk);
    drive_req(2'b01, 32'd60, 32'd5, 5'd6, IW'(6));
    @(negedge clk);
    flush = 1'b1;
    drive_req(2'b01, 32'd70, 32'd7, 5'd7, IW'(7));
    #1;
    chk("flush_req_ready", s_req_ready, 0);
    chk("flush_div_req_valid", m_div_req_valid, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_res_valid", m_res_valid, 0);
    m_div_req_ready = 1'b0;
    drive_req(2'b01, 32'd40, 32'd2, 5'd4, IW'(4));
    #1;
    chk("flush_hit_blocked_by_kill", m_div_req_valid, 1);
    chk("flush_hit_blocked_ready", s_req_ready, 0);
    s_req_valid = 1'b0;
    m_div_req_ready = 1'b1;
    div_ret(32'd10, 5'd5, IW'(5));
    #1;
    chk("kill0_ready", s_div_res_ready, 1);
    @(negedge clk);
    chk("kill0_dropped", m_res_valid, 0);
    div_ret(32'd12, 5'd6, IW'(6));
    #1;
    chk("kill1_ready", s_div_res_ready, 1);
    @(negedge clk);
    s_div_res_valid = 1'b0;
    chk("kill1_dropped", m_res_valid, 0);
    drive_req(2'b01, 32'd40, 32'd2, 5'd4, IW'(4));
    #1;
    chk("post_flush_cache_hit", m_div_req_valid, 0);
    @(negedge clk);
    s_req_valid = 1'b0;
    chk("post_flush_cache_data", m_res_data, 20);
    drive_req(2'b01, 32'd9, 32'd3, 5'd9, IW'(9));
    #1;
    chk("post_flush_miss", m_div_req_valid, 1);
    @(negedge clk);
    s_req_valid = 1'b0;
    div_ret(32'd3, 5'd9, IW'(9));
    @(negedge clk);
    s_div_res_valid = 1'b0;
    chk("post_flush_res_valid", m_res_valid, 1);
    chk("post_flush_res_data", m_res_data, 3);
    chk("post_flush_res_iid", m_res_inst_id, 9);

    // Writeback backpressure, then reset
    @(negedge clk);
    m_res_ready = 1'b0;
    drive_req(2'b01, 32'd7, 32'd7, 5'd7, IW'(7));
    @(negedge clk);
    s_req_valid = 1'b0;
    div_ret(32'd1, 5'd7, IW'(7));
    @(negedge clk);
    s_div_res_valid = 1'b0;
    chk("bp_res0_valid", m_res_valid, 1);
    drive_req(2'b01, 32'd7, 32'd7, 5'd2, IW'(2));
    #1;
    chk("bp_hit_waits_for_output", s_req_ready, 0);
    chk("bp_hit_no_div_req", m_div_req_valid, 0);
    drive_req(2'b01, 32'd8, 32'd8, 5'd8, IW'(8));
    #1;
    chk("bp_miss_issue_ready", s_req_ready, 1);
    @(negedge clk);
    s_req_valid = 1'b0;
    div_ret(32'd1, 5'd8, IW'(8));
    #1;
    chk("bp_div_res_held", s_div_res_ready, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", k), m_res_valid, 1);
      chk($sformatf("bp_hold%0d_iid", k), m_res_inst_id, 7);
      chk($sformatf("bp_hold%0d_rd", k), m_res_rd_id, 7);
    end
    m_res_ready = 1'b1;
    #1;
    chk("bp_div_res_released", s_div_res_ready, 1);
    @(negedge clk);
    m_res_ready = 1'b0;
    s_div_res_valid = 1'b0;
    chk("bp_res1_valid", m_res_valid, 1);
    chk("bp_res1_iid", m_res_inst_id, 8);
    @(negedge clk);
    chk("bp_res1_held", m_res_inst_id, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_res_valid", m_res_valid, 0);
    m_res_ready = 1'b1;
    drive_req(2'b01, 32'd8, 32'd8, 5'd8, IW'(8));
    #1;
    chk("rst_cache_invalid", m_div_req_valid, 1);
    @(negedge clk);
    s_req_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
